// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port SRAM between two req/gnt/rvalid hosts.
// Ports: clk_i/rst_i clock and sync active-high reset; h_*_i/h_*_o per-host
// request, grant, command and response signals, index [h] selects host 0 or 1;
// ram_*_o/ram_rdata_i connect to the 1-cycle-latency RAM macro.
module sram_arbiter #(
  parameter int Aw = 11,
  parameter int Dw = 32,
  parameter bit RoundRobin = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [1:0]          h_req_i,
  output logic [1:0]          h_gnt_o,
  input  logic [1:0]          h_we_i,
  input  logic [1:0][Aw-1:0]  h_addr_i,
  input  logic [1:0][Dw-1:0]  h_wdata_i,
  input  logic [1:0][Dw-1:0]  h_wmask_i,
  output logic [1:0][Dw-1:0]  h_rdata_o,
  output logic [1:0]          h_rvalid_o,
  output logic                ram_req_o,
  output logic                ram_we_o,
  output logic [Aw-1:0]       ram_addr_o,
  output logic [Dw-1:0]       ram_wdata_o,
  output logic [Dw-1:0]       ram_wmask_o,
  input  logic [Dw-1:0]       ram_rdata_i
);
  logic r_last;
  logic r_rd_pend;
  logic r_rd_owner;
  logic w_sel;
  // A lone requester always wins; a conflict goes to the host not served last,
  // or to host 0 when round-robin is disabled.
  always_comb begin
    w_sel = (&h_req_i) ? (RoundRobin ? ~r_last : 1'b0) : h_req_i[1];
    ram_req_o = |h_req_i;
    h_gnt_o = {w_sel, ~w_sel} & {2{ram_req_o}};
    ram_we_o = ram_req_o & h_we_i[w_sel];
    ram_addr_o = ram_req_o ? h_addr_i[w_sel] : '0;
    ram_wdata_o = ram_req_o ? h_wdata_i[w_sel] : '0;
    ram_wmask_o = ram_req_o ? h_wmask_i[w_sel] : '0;
    h_rdata_o = {ram_rdata_i, ram_rdata_i};
    h_rvalid_o = {r_rd_owner, ~r_rd_owner} & {2{r_rd_pend & ~rst_i}};
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last <= 1'b1;
      r_rd_pend <= 1'b0;
      r_rd_owner <= 1'b0;
    end else begin
      if (ram_req_o) r_last <= w_sel;
      r_rd_pend <= ram_req_o & ~h_we_i[w_sel];
      r_rd_owner <= w_sel;
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: checks fixed-priority and round-robin arbiters against a reference model.
module tb_sram_arbiter;
  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;
  logic [1:0] req, we;
  logic [1:0][10:0] addr;
  logic [1:0][31:0] wd, wm;
  logic [1:0] gnt [2];
  logic [1:0] rv [2];
  logic [1:0][31:0] rd [2];
  logic rq [2];
  logic rwe [2];
  logic [10:0] ra [2];
  logic [31:0] rwd [2];
  logic [31:0] rwm [2];
  logic [31:0] rrd [2];
  logic [1:0] gl [2];
  int passed = 0;
  int total = 0;
  bit last [2];
  int pend [2];
  logic [31:0] pdata [2];
  logic [31:0] mm [2][2048];
  sram_arbiter #(.RoundRobin(1'b0)) u_fix (
    .clk_i(clk_i), .rst_i(rst_i), .h_req_i(req), .h_gnt_o(gnt[0]), .h_we_i(we),
    .h_addr_i(addr), .h_wdata_i(wd), .h_wmask_i(wm), .h_rdata_o(rd[0]), .h_rvalid_o(rv[0]),
    .ram_req_o(rq[0]), .ram_we_o(rwe[0]), .ram_addr_o(ra[0]), .ram_wdata_o(rwd[0]),
    .ram_wmask_o(rwm[0]), .ram_rdata_i(rrd[0]));
  sram_arbiter #(.RoundRobin(1'b1)) u_rr (
    .clk_i(clk_i), .rst_i(rst_i), .h_req_i(req), .h_gnt_o(gnt[1]), .h_we_i(we),
    .h_addr_i(addr), .h_wdata_i(wd), .h_wmask_i(wm), .h_rdata_o(rd[1]), .h_rvalid_o(rv[1]),
    .ram_req_o(rq[1]), .ram_we_o(rwe[1]), .ram_addr_o(ra[1]), .ram_wdata_o(rwd[1]),
    .ram_wmask_o(rwm[1]), .ram_rdata_i(rrd[1]));
  for (genvar k = 0; k < 2; k++) begin : g_ram
    logic [31:0] mem [2048];
    logic [31:0] q;
    initial begin
      q <= '0;
      for (int i = 0; i < 2048; i++) mem[i] <= '0;
    end
    always @(posedge clk_i)
      if (rq[k]) begin
        if (rwe[k]) mem[ra[k]] <= (mem[ra[k]] & ~rwm[k]) | (rwd[k] & rwm[k]);
        else q <= mem[ra[k]];
      end
    assign rrd[k] = q;
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic step(input bit r, input logic [1:0] q, input logic [1:0] w,
                      input logic [10:0] a0, input logic [10:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic [31:0] m0, input logic [31:0] m1);
    int win [2];
    logic [1:0] eg;
    logic [76:0] ec;
    rst_i = r; req = q; we = w;
    addr = {a1, a0}; wd = {d1, d0}; wm = {m1, m0};
    @(negedge clk_i);
    for (int m = 0; m < 2; m++) begin
      win[m] = q == 2'b00 ? -1 : q == 2'b11 ? (m == 1 && !last[m] ? 1 : 0) : (q[1] ? 1 : 0);
      eg = win[m] < 0 ? 2'b00 : 2'(1 << win[m]);
      ec = win[m] < 0 ? '0 : {1'b1, w[win[m]], addr[win[m]], wd[win[m]], wm[win[m]]};
      gl[m] = gnt[m];
      chk($sformatf("gnt_m%0d", m), 128'(gnt[m]), 128'(eg));
      chk($sformatf("ramcmd_m%0d", m), 128'({rq[m], rwe[m], ra[m], rwd[m], rwm[m]}), 128'(ec));
      chk($sformatf("rvalid_m%0d", m), 128'(rv[m]), (r || pend[m] < 0) ? 128'(0) : 128'(1 << pend[m]));
      if (!r && pend[m] >= 0) chk($sformatf("rdata_m%0d", m), 128'(rd[m]), 128'({pdata[m], pdata[m]}));
    end
    @(posedge clk_i);
    for (int m = 0; m < 2; m++) begin
      pend[m] = -1;
      if (win[m] >= 0) begin
        last[m] = win[m][0];
        if (w[win[m]]) mm[m][addr[win[m]]] = (mm[m][addr[win[m]]] & ~wm[win[m]]) | (wd[win[m]] & wm[win[m]]);
        else begin
          pend[m] = win[m];
          pdata[m] = mm[m][addr[win[m]]];
        end
      end
      if (r) begin
        last[m] = 1'b1;
        pend[m] = -1;
      end
    end
    #1;
  endtask
  initial begin
    for (int m = 0; m < 2; m++) begin
      pend[m] = -1;
      last[m] = 1'b1;
      for (int i = 0; i < 2048; i++) mm[m][i] = '0;
    end
    step(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    step(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    step(0, 2'b01, 2'b01, 11'h010, 0, 32'hDEADBEEF, 0, 32'hFFFFFFFF, 0);
    step(0, 2'b01, 2'b00, 11'h010, 0, 0, 0, 0, 0);
    chk("rd_after_wr_rv", 128'(rv[1]), 128'(2'b01));
    chk("rd_after_wr_data", 128'(rd[1][0]), 128'(32'hDEADBEEF));
    step(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 2'b11, 2'b00, 11'(i), 11'(i + 8), 0, 0, 0, 0);
      chk($sformatf("rr_seq%0d", i), 128'(gl[1]), i % 2 ? 128'(2'b10) : 128'(2'b01));
      chk($sformatf("rr_rvalid%0d", i), 128'(rv[1]), i % 2 ? 128'(2'b10) : 128'(2'b01));
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 2'b11, 2'b00, 11'(i), 11'(i + 8), 0, 0, 0, 0);
      chk($sformatf("fix_starve%0d", i), 128'(gl[0]), 128'(2'b01));
    end
    step(0, 2'b10, 2'b00, 0, 11'h009, 0, 0, 0, 0);
    chk("fix_release", 128'(gl[0]), 128'(2'b10));
    step(0, 2'b10, 2'b10, 0, 11'h7FF, 0, 32'hAAAAAAAA, 0, 32'hFFFFFFFF);
    step(0, 2'b10, 2'b10, 0, 11'h7FF, 0, 32'h11223344, 0, 32'h0000FF00);
    step(0, 2'b10, 2'b00, 0, 11'h7FF, 0, 0, 0, 0);
    chk("bytemask_data", 128'(rd[1][1]), 128'(32'hAAAA33AA));
    step(1, 2'b01, 2'b00, 11'h010, 0, 0, 0, 0, 0);
    chk("rst_mid_read", 128'({rv[0], rv[1]}), 128'(0));
    step(0, 2'b11, 2'b00, 11'h001, 11'h002, 0, 0, 0, 0);
    chk("rst_first_conflict", 128'(gl[1]), 128'(2'b01));
    step(0, 2'b10, 2'b10, 0, 11'h020, 0, 32'h5, 0, 32'hF);
    step(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    step(0, 2'b10, 2'b10, 0, 11'h021, 0, 32'h6, 0, 32'hF);
    step(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    step(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    chk("idle_no_rvalid", 128'({rv[0], rv[1]}), 128'(0));
    step(0, 2'b11, 2'b11, 11'h030, 11'h031, 1, 2, 32'hF, 32'hF);
    chk("idle_hold_last", 128'(gl[1]), 128'(2'b01));
    for (int i = 0; i < 400; i++)
      step($urandom_range(39) == 0, 2'($urandom), 2'($urandom),
           $urandom_range(9) == 0 ? 11'h7FF : 11'($urandom_range(7)), 11'($urandom_range(7)),
           $urandom, $urandom, $urandom, $urandom);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
